// File: rtl/instr_fetch.sv
// Instruction-fetch reader: takes the PC, issues a read to instruction
// memory with a ready/wait handshake and latches the returned word into
// the instruction register. It flags misaligned PCs and memory time-outs.
module instr_fetch #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               fetch_start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic               busy,
  output logic               fetch_err
);

  // The counter must be able to hold TIMEOUT itself, so the width is
  // ceil(log2(TIMEOUT+1)). TIMEOUT == 1 still needs one bit.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;

  // Fetch state machine: launches the read, waits for ready or time-out,
  // and routes misaligned requests straight to the one-cycle error state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
      wait_cnt <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          mem_rd <= 1'b0;
          if (fetch_start) begin
            if (pc_in[1:0] != 2'b00) begin
              state <= ERR;
            end else begin
              mem_addr <= pc_in;
              mem_rd   <= 1'b1;
              wait_cnt <= '0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            ir_out   <= mem_rdata;
            ir_valid <= 1'b1;
            mem_rd   <= 1'b0;
            state    <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_rd <= 1'b0;
            state  <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Status flags decoded directly from the state register, so busy and
  // fetch_err follow the state with no extra cycle of delay.
  always_comb begin
    busy      = (state != IDLE);
    fetch_err = (state == ERR);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: zero-wait, wait-state, misaligned,
// time-out, ignored request, reset mid-fetch and back-to-back fetches.
module tb_instr_fetch;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int TIMEOUT = 16;

  logic               CLK;
  logic               RST;
  logic [ADDR_W-1:0]  pc_in;
  logic               fetch_start;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir_out;
  logic               ir_valid;
  logic               busy;
  logic               fetch_err;

  int checks;
  int passed;
  int cyc;

  instr_fetch #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pc_in(pc_in),
    .fetch_start(fetch_start),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .ir_out(ir_out),
    .ir_valid(ir_valid),
    .busy(busy),
    .fetch_err(fetch_err)
  );

  // Free-running clock, 10 ns period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic start, input logic [ADDR_W-1:0] pc,
                               input logic ready, input logic [INSTR_W-1:0] rdata);
    fetch_start = start;
    pc_in       = pc;
    mem_ready   = ready;
    mem_rdata   = rdata;
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    int rd_cnt;
    int err_at;
    int v1_cyc;
    int v2_cyc;
    logic [ADDR_W-1:0] held_addr;

    checks = 0;
    passed = 0;
    cyc    = 0;
    RST    = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_ir_out", ir_out, 0);
    checkOutput("rst_ir_valid", ir_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fetch_err", fetch_err, 0);
    RST = 1'b0;

    // Zero-wait fetch at 0x40.
    applyStimulus(1'b1, 64'h40, 1'b0, '0);
    tick();
    checkOutput("zw_mem_rd", mem_rd, 1);
    checkOutput("zw_mem_addr", mem_addr, 64'h40);
    checkOutput("zw_busy", busy, 1);
    checkOutput("zw_ir_valid_early", ir_valid, 0);
    applyStimulus(1'b0, 64'h0, 1'b1, 32'h0000_0093);
    tick();
    checkOutput("zw_ir_valid", ir_valid, 1);
    checkOutput("zw_ir_out", ir_out, 32'h0000_0093);
    checkOutput("zw_mem_rd_low", mem_rd, 0);
    checkOutput("zw_busy_low", busy, 0);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    tick();
    checkOutput("zw_ir_valid_pulse", ir_valid, 0);

    // Stray mem_ready while idle must not load the IR.
    applyStimulus(1'b0, 64'h0, 1'b1, 32'hFFFF_FFFF);
    tick();
    checkOutput("idle_ready_ir_valid", ir_valid, 0);
    checkOutput("idle_ready_ir_out", ir_out, 32'h0000_0093);

    // Three wait states, with an ignored second fetch_start during the wait.
    applyStimulus(1'b1, 64'h80, 1'b0, '0);
    tick();
    rd_cnt    = int'(mem_rd);
    held_addr = mem_addr;
    checkOutput("ws_addr", mem_addr, 64'h80);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'h200, 1'b0, 32'hBAD0_BAD0);
      tick();
      rd_cnt += int'(mem_rd);
      checkOutput("ws_addr_stable", mem_addr, held_addr);
      checkOutput("ws_no_valid", ir_valid, 0);
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 32'h00A0_0513);
    tick();
    rd_cnt += int'(mem_rd);
    checkOutput("ws_ir_valid", ir_valid, 1);
    checkOutput("ws_ir_out", ir_out, 32'h00A0_0513);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      rd_cnt += int'(mem_rd);
    end
    checkOutput("ws_rd_cycles", 64'(rd_cnt), 4);
    checkOutput("ws_addr_after", mem_addr, 64'h80);
    checkOutput("ws_busy_after", busy, 0);

    // Misaligned PC.
    applyStimulus(1'b1, 64'h42, 1'b0, '0);
    tick();
    checkOutput("mis_mem_rd", mem_rd, 0);
    checkOutput("mis_fetch_err", fetch_err, 1);
    checkOutput("mis_busy", busy, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    tick();
    checkOutput("mis_err_pulse", fetch_err, 0);
    checkOutput("mis_busy_after", busy, 0);
    checkOutput("mis_ir_out", ir_out, 32'h00A0_0513);
    checkOutput("mis_ir_valid", ir_valid, 0);

    // Time-out: memory never answers.
    applyStimulus(1'b1, 64'h100, 1'b0, '0);
    tick();
    rd_cnt = int'(mem_rd);
    err_at = -1;
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    for (int i = 1; i <= 24; i++) begin
      tick();
      rd_cnt += int'(mem_rd);
      if (fetch_err && err_at < 0) err_at = i;
    end
    checkOutput("to_rd_cycles", 64'(rd_cnt), 16);
    checkOutput("to_err_cycle", 64'(err_at), 16);
    checkOutput("to_busy", busy, 0);
    checkOutput("to_ir_out", ir_out, 32'h00A0_0513);
    applyStimulus(1'b1, 64'h8, 1'b0, '0);
    tick();
    checkOutput("to_next_rd", mem_rd, 1);
    checkOutput("to_next_addr", mem_addr, 64'h8);
    applyStimulus(1'b0, 64'h0, 1'b1, 32'h0000_0013);
    tick();
    checkOutput("to_next_valid", ir_valid, 1);
    checkOutput("to_next_ir", ir_out, 32'h0000_0013);

    // Reset mid-REQ with mem_ready in the same cycle.
    applyStimulus(1'b1, 64'hC, 1'b0, '0);
    tick();
    checkOutput("rq_mem_rd", mem_rd, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF);
    RST = 1'b1;
    tick();
    checkOutput("rq_ir_out", ir_out, 0);
    checkOutput("rq_ir_valid", ir_valid, 0);
    checkOutput("rq_mem_rd_low", mem_rd, 0);
    checkOutput("rq_mem_addr", mem_addr, 0);
    checkOutput("rq_busy", busy, 0);
    checkOutput("rq_fetch_err", fetch_err, 0);
    RST = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    tick();

    // Back-to-back fetches at 0x0 and 0x4.
    v1_cyc = -1;
    v2_cyc = -1;
    applyStimulus(1'b1, 64'h0, 1'b0, '0);
    tick();
    checkOutput("bb_addr0", mem_addr, 64'h0);
    checkOutput("bb_rd0", mem_rd, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 32'h1111_1111);
    tick();
    if (ir_valid) v1_cyc = cyc;
    checkOutput("bb_ir0", ir_out, 32'h1111_1111);
    applyStimulus(1'b1, 64'h4, 1'b0, '0);
    tick();
    checkOutput("bb_addr1", mem_addr, 64'h4);
    checkOutput("bb_rd1", mem_rd, 1);
    applyStimulus(1'b0, 64'h0, 1'b1, 32'h2222_2222);
    tick();
    if (ir_valid) v2_cyc = cyc;
    checkOutput("bb_ir1", ir_out, 32'h2222_2222);
    checkOutput("bb_valid0_seen", 64'(v1_cyc >= 0), 1);
    checkOutput("bb_spacing", 64'(v2_cyc - v1_cyc), 2);
    applyStimulus(1'b0, 64'h0, 1'b0, '0);
    tick();
    checkOutput("bb_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
